// File: rtl/miriscv_lsu_pkg.sv
//------------------------------------------------------------------------------
// Module : miriscv_lsu_pkg
// Brief  : Shared encodings and helpers for the miriscv load-store unit.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package miriscv_lsu_pkg;

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } lsu_state_e;

  // Unknown size codes and accesses crossing their natural alignment are rejected.
  function automatic logic lsu_access_illegal(input logic [2:0] size, input logic [1:0] offset);
    logic illegal;
    case (size)
      LDST_B, LDST_BU: illegal = 1'b0;
      LDST_H, LDST_HU: illegal = offset[0];
      LDST_W:          illegal = (offset != 2'b00);
      default:         illegal = 1'b1;
    endcase
    return illegal;
  endfunction

endpackage

`default_nettype wire

// File: rtl/miriscv_lsu_rdata_align.sv
//------------------------------------------------------------------------------
// Module : miriscv_lsu_rdata_align
// Brief  : Moves the addressed load lane to bit 0 and sign/zero-extends it.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module miriscv_lsu_rdata_align
  import miriscv_lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  size,
  output logic [31:0] data
);

  logic [31:0] w_shifted;

  always_comb begin
    w_shifted = rdata >> {offset, 3'b000};
    case (size)
      LDST_B:  data = {{24{w_shifted[7]}},  w_shifted[7:0]};
      LDST_BU: data = {24'd0,               w_shifted[7:0]};
      LDST_H:  data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      LDST_HU: data = {16'd0,               w_shifted[15:0]};
      default: data = w_shifted;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/miriscv_lsu.sv
//------------------------------------------------------------------------------
// Module : miriscv_lsu
// Brief  : Load-store unit: core request -> req/rvalid data memory access.
//          Optional WAIT-state abort enabled by MIRISCV_LSU_TIMEOUT_EN.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module miriscv_lsu
  import miriscv_lsu_pkg::*;
`ifdef MIRISCV_LSU_TIMEOUT_EN
  #(parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT)
`endif
(
  input  logic        clk,
  input  logic        reset,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [2:0]  lsu_size_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_data_i,
  output logic [31:0] lsu_data_o,
  output logic        lsu_stall_req_o,
  output logic        lsu_err_o,
  output logic        data_req_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic [31:0] data_rdata_i,
  input  logic        data_rvalid_i
);

  lsu_state_e  r_state;
  logic [1:0]  r_offset;
  logic [2:0]  r_size;
  logic        r_we;

  logic        w_illegal;
  logic        w_accept;
  logic        w_timeout_done;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_rdata_ext;

`ifdef MIRISCV_LSU_TIMEOUT_EN
  localparam int unsigned       c_cnt_w    = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                             $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

  logic [c_cnt_w-1:0] r_cnt;
  logic               r_timeout;

  assign w_timeout_done = r_timeout;
`else
  assign w_timeout_done = 1'b0;
`endif

  always_comb begin
    w_illegal       = lsu_access_illegal(lsu_size_i, lsu_addr_i[1:0]);
    w_accept        = (r_state == IDLE) && lsu_req_i && !w_illegal;
    lsu_stall_req_o = w_accept || (r_state == WAIT);
    lsu_err_o       = ((r_state == IDLE) && lsu_req_i && w_illegal) ||
                      ((r_state == DONE) && w_timeout_done);

    case (lsu_size_i)
      LDST_B, LDST_BU: w_be = 4'b0001 << lsu_addr_i[1:0];
      LDST_H, LDST_HU: w_be = 4'b0011 << {lsu_addr_i[1], 1'b0};
      default:         w_be = 4'b1111;
    endcase

    // Replicate the store operand across every lane so memory picks it via byte enables.
    case (lsu_size_i[1:0])
      2'b00:   w_wdata = {4{lsu_data_i[7:0]}};
      2'b01:   w_wdata = {2{lsu_data_i[15:0]}};
      default: w_wdata = lsu_data_i;
    endcase
  end

  miriscv_lsu_rdata_align u_rdata_align (
    .rdata  (data_rdata_i),
    .offset (r_offset),
    .size   (r_size),
    .data   (w_rdata_ext)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_offset     <= 2'd0;
      r_size       <= 3'd0;
      r_we         <= 1'b0;
      lsu_data_o   <= 32'd0;
      data_req_o   <= 1'b0;
      data_we_o    <= 1'b0;
      data_be_o    <= 4'd0;
      data_addr_o  <= 32'd0;
      data_wdata_o <= 32'd0;
`ifdef MIRISCV_LSU_TIMEOUT_EN
      r_cnt        <= '0;
      r_timeout    <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_offset     <= lsu_addr_i[1:0];
            r_size       <= lsu_size_i;
            r_we         <= lsu_we_i;
            data_req_o   <= 1'b1;
            data_we_o    <= lsu_we_i;
            data_be_o    <= w_be;
            data_addr_o  <= {lsu_addr_i[31:2], 2'b00};
            data_wdata_o <= w_wdata;
            r_state      <= WAIT;
`ifdef MIRISCV_LSU_TIMEOUT_EN
            r_cnt        <= '0;
            r_timeout    <= 1'b0;
`endif
          end
        end
        WAIT: begin
          if (data_rvalid_i) begin
            data_req_o <= 1'b0;
            if (!r_we) lsu_data_o <= w_rdata_ext;
            r_state    <= DONE;
          end
`ifdef MIRISCV_LSU_TIMEOUT_EN
          else if (r_cnt == c_cnt_last) begin
            data_req_o <= 1'b0;
            r_timeout  <= 1'b1;
            r_state    <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end
        DONE: begin
          r_state <= IDLE;
`ifdef MIRISCV_LSU_TIMEOUT_EN
          r_timeout <= 1'b0;
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_miriscv_lsu.sv
//------------------------------------------------------------------------------
// Module : tb_miriscv_lsu
// Brief  : Self-checking bench for miriscv_lsu (directed + random accesses).
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_miriscv_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        lsu_req_i;
  logic        lsu_we_i;
  logic [2:0]  lsu_size_i;
  logic [31:0] lsu_addr_i;
  logic [31:0] lsu_data_i;
  logic [31:0] lsu_data_o;
  logic        lsu_stall_req_o;
  logic        lsu_err_o;
  logic        data_req_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o;
  logic [31:0] data_wdata_o;
  logic [31:0] data_rdata_i;
  logic        data_rvalid_i;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_data = 32'd0;

  always #5 clk = ~clk;

  miriscv_lsu dut (
    .clk             (clk),
    .reset           (reset),
    .lsu_req_i       (lsu_req_i),
    .lsu_we_i        (lsu_we_i),
    .lsu_size_i      (lsu_size_i),
    .lsu_addr_i      (lsu_addr_i),
    .lsu_data_i      (lsu_data_i),
    .lsu_data_o      (lsu_data_o),
    .lsu_stall_req_o (lsu_stall_req_o),
    .lsu_err_o       (lsu_err_o),
    .data_req_o      (data_req_o),
    .data_we_o       (data_we_o),
    .data_be_o       (data_be_o),
    .data_addr_o     (data_addr_o),
    .data_wdata_o    (data_wdata_o),
    .data_rdata_i    (data_rdata_i),
    .data_rvalid_i   (data_rvalid_i)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: access width in bytes, legality, lanes and load result.
  function automatic int nbytes(input logic [2:0] size);
    return (size[1:0] == 2'd0) ? 1 : (size[1:0] == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit m_legal(input logic [2:0] size, input logic [31:0] addr);
    if (size == 3 || size > 5) return 0;
    return (addr % nbytes(size)) == 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] size, input logic [31:0] addr);
    logic [3:0] be;
    int off = int'(addr % 4);
    for (int i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + nbytes(size));
    return be;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] size, input logic [31:0] d);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % nbytes(size)) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] size, input logic [31:0] addr,
                                         input logic [31:0] rd);
    longint unsigned v, full;
    v    = longint'(rd) >> (8 * (addr % 4));
    full = 64'd1 << (8 * nbytes(size));
    v    = v % full;
    if (size < 4 && v >= full / 2) v = v + 64'h1_0000_0000 - full;
    return v[31:0];
  endfunction

  task automatic do_access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] rd, input int lat);
    int stalls = 0;
    lsu_req_i  = 1'b1;
    lsu_we_i   = we;
    lsu_size_i = size;
    lsu_addr_i = addr;
    lsu_data_i = wd;
    #1;
    check("accept_err", {31'd0, lsu_err_o}, 32'd0);
    if (lsu_stall_req_o) stalls++;
    step();
    check("req_o", {31'd0, data_req_o}, 32'd1);
    check("we_o", {31'd0, data_we_o}, {31'd0, we});
    check("addr_o", data_addr_o, addr & 32'hFFFF_FFFC);
    check("be_o", {28'd0, data_be_o}, {28'd0, m_be(size, addr)});
    if (we) check("wdata_o", data_wdata_o, m_wdata(size, wd));
    for (int i = 0; i < lat; i++) begin
      if (lsu_stall_req_o) stalls++;
      step();
    end
    data_rvalid_i = 1'b1;
    data_rdata_i  = rd;
    if (lsu_stall_req_o) stalls++;
    step();
    data_rvalid_i = 1'b0;
    data_rdata_i  = $urandom;
    if (!we) exp_data = m_load(size, addr, rd);
    check("done_stall", {31'd0, lsu_stall_req_o}, 32'd0);
    check("done_req", {31'd0, data_req_o}, 32'd0);
    check("done_err", {31'd0, lsu_err_o}, 32'd0);
    check("stall_cycles", stalls, 2 + lat);
    check("lsu_data", lsu_data_o, exp_data);
    step();
    check("no_reaccept", {31'd0, data_req_o}, 32'd0);
    lsu_req_i = 1'b0;
    #1;
  endtask

  task automatic do_illegal(input logic [2:0] size, input logic [31:0] addr);
    lsu_req_i  = 1'b1;
    lsu_we_i   = $urandom_range(0, 1);
    lsu_size_i = size;
    lsu_addr_i = addr;
    #1;
    check("illegal_err", {31'd0, lsu_err_o}, 32'd1);
    check("illegal_stall", {31'd0, lsu_stall_req_o}, 32'd0);
    step();
    check("illegal_noreq", {31'd0, data_req_o}, 32'd0);
    lsu_req_i = 1'b0;
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  sz;
    logic [31:0] ad;
    reset         = 1'b0;
    lsu_req_i     = 1'b0;
    lsu_we_i      = 1'b0;
    lsu_size_i    = 3'd0;
    lsu_addr_i    = 32'd0;
    lsu_data_i    = 32'd0;
    data_rdata_i  = 32'd0;
    data_rvalid_i = 1'b0;
    step();
    step();
    check("rst_data", lsu_data_o, 32'd0);
    check("rst_req", {31'd0, data_req_o}, 32'd0);
    check("rst_addr", data_addr_o, 32'd0);
    check("rst_stall_err", {30'd0, lsu_stall_req_o, lsu_err_o}, 32'd0);
    reset = 1'b1;
    step();

    do_access(1'b1, 3'd2, 32'h100, 32'hDEAD_BEEF, 32'd0, 0);
    do_access(1'b0, 3'd0, 32'h103, 32'd0, 32'h80FF_0000, 0);
    check("lb_const", lsu_data_o, 32'hFFFF_FF80);
    do_access(1'b0, 3'd4, 32'h103, 32'd0, 32'h80FF_0000, 1);
    check("lbu_const", lsu_data_o, 32'h0000_0080);
    do_access(1'b1, 3'd1, 32'h102, 32'h0000_1234, 32'd0, 2);
    do_access(1'b0, 3'd1, 32'h102, 32'd0, {16'h8001, 16'($urandom)}, 0);
    check("lh_const", lsu_data_o, 32'hFFFF_8001);
    do_illegal(3'd2, 32'h102);
    do_illegal(3'd3, 32'h100);
    check("err_keeps_data", lsu_data_o, 32'hFFFF_8001);

    // Stray rvalid in IDLE must not touch the load result.
    data_rvalid_i = 1'b1;
    data_rdata_i  = 32'h1234_5678;
    step();
    data_rvalid_i = 1'b0;
    check("stray_rvalid", lsu_data_o, exp_data);

    for (int n = 0; n < 60; n++) begin
      sz = 3'($urandom_range(0, 7));
      ad = $urandom;
      if (m_legal(sz, ad))
        do_access(1'($urandom_range(0, 1)), sz, ad, $urandom, $urandom, $urandom_range(0, 3));
      else
        do_illegal(sz, ad);
    end

    // Reset in the middle of a WAIT drops the access.
    lsu_req_i  = 1'b1;
    lsu_we_i   = 1'b0;
    lsu_size_i = 3'd2;
    lsu_addr_i = 32'h200;
    step();
    check("wait_req", {31'd0, data_req_o}, 32'd1);
    lsu_req_i = 1'b0;
    reset     = 1'b0;
    step();
    reset    = 1'b1;
    exp_data = 32'd0;
    check("rstw_req", {31'd0, data_req_o}, 32'd0);
    check("rstw_stall", {31'd0, lsu_stall_req_o}, 32'd0);
    check("rstw_data", lsu_data_o, 32'd0);
    data_rvalid_i = 1'b1;
    data_rdata_i  = 32'hCAFE_F00D;
    step();
    data_rvalid_i = 1'b0;
    check("rstw_late_rvalid", lsu_data_o, 32'd0);
    do_access(1'b0, 3'd2, 32'h204, 32'd0, 32'h0BAD_F00D, 1);

`ifdef MIRISCV_LSU_TIMEOUT_EN
    lsu_req_i  = 1'b1;
    lsu_we_i   = 1'b0;
    lsu_size_i = 3'd2;
    lsu_addr_i = 32'h300;
    step();
    lsu_req_i = 1'b0;
    for (int i = 0; i < 254; i++) step();
    check("to_req_held", {31'd0, data_req_o}, 32'd1);
    step();
    check("to_req_drop", {31'd0, data_req_o}, 32'd0);
    check("to_err", {31'd0, lsu_err_o}, 32'd1);
    check("to_stall", {31'd0, lsu_stall_req_o}, 32'd0);
    check("to_data", lsu_data_o, exp_data);
    data_rvalid_i = 1'b1;
    data_rdata_i  = 32'h5555_AAAA;
    step();
    data_rvalid_i = 1'b0;
    check("to_err_clear", {31'd0, lsu_err_o}, 32'd0);
    check("to_late_rvalid", lsu_data_o, exp_data);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/miriscv_lsu.md
# miriscv_lsu

Load-store unit between the miriscv single-cycle core's execute/writeback path and the data memory. It accepts one load or store per core request, presents it to memory over a req/rvalid handshake with byte enables, and stalls the core until completion. It returns the sign- or zero-extended load result and flags illegal or misaligned accesses.

## Interface

- TIMEOUT_CYCLES, 255: WAIT-state cycles before abort (only with the timeout feature).
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset.
- lsu_req_i  input  1  core requests a memory access; held until stall drops.
- lsu_we_i  input  1  1 = store, 0 = load.
- lsu_size_i  input  3  funct3 encoding: 0 B, 1 H, 2 W, 4 BU, 5 HU; 3/6/7 illegal.
- lsu_addr_i  input  32  byte address (ALU result).
- lsu_data_i  input  32  store data (rs2).
- lsu_data_o  output  32  extended load result, registered.
- lsu_stall_req_o  output  1  core must hold PC and writeback.
- lsu_err_o  output  1  illegal size, misaligned access, or timeout.
- data_req_o  output  1  memory request, held until rvalid.
- data_we_o  output  1  memory write enable.
- data_be_o  output  4  byte enables.
- data_addr_o  output  32  word-aligned address, {lsu_addr_i[31:2], 2'b00}.
- data_wdata_o  output  32  lane-replicated store data.
- data_rdata_i  input  32  memory read word.
- data_rvalid_i  input  1  one-cycle completion pulse; ends the access for both loads and stores.

## Operation

- States: IDLE, WAIT, DONE.
- IDLE, lsu_req_i=1, legal: stall=1. At the clock edge: latch addr[1:0], size and we; register data_req_o=1, data_we_o, data_be_o, data_addr_o and data_wdata_o; go to WAIT.
- IDLE, lsu_req_i=1, illegal (size 3/6/7, H/HU with addr[0]=1, W with addr[1:0]≠0): lsu_err_o=1 (combinational), stall=0, no memory request, stay in IDLE.
- WAIT: stall=1 and memory outputs held. When data_rvalid_i=1:
  - data_req_o goes to 0 at the next edge.
  - For loads, lsu_data_o is registered at that edge.
  - Go to DONE.
- DONE: stall=0 for exactly one cycle, then go to IDLE unconditionally. The still-high lsu_req_i in DONE is not re-accepted.
- Byte enables:
  - B: 4'b0001<<addr[1:0].
  - H: 4'b0011<<{addr[1],1'b0}.
  - W: 4'b1111.
- Store data: B → {4{d[7:0]}}; H → {2{d[15:0]}}; W → d.
- Load extraction: shift right by 8*addr[1:0], then:
  - B/H: sign-extend bit 7/15.
  - BU/HU: zero-extend.
- lsu_data_o is unchanged on stores, errors and timeouts.
- data_rvalid_i outside WAIT is ignored.
- Reset (reset=0) at any point: state IDLE; all outputs 0, including stall and err, in the following cycle; any in-flight access is dropped.

## Timing

- Minimum access is 3 cycles (IDLE accept, WAIT, DONE), with stall high for 2. This requires rvalid in the first WAIT cycle.
- Each extra memory wait cycle adds one stall cycle.
- lsu_data_o is valid from the start of DONE until the next load completes.
- lsu_err_o for illegal accesses is combinational in the same cycle as the request. For a timeout it is high during DONE only.
- Reset values: lsu_data_o, data_* outputs, lsu_err_o and lsu_stall_req_o are all 0.

## Configuration

- MIRISCV_LSU_TIMEOUT_EN defined:
  - An 8-bit-or-wider counter clears on WAIT entry and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES without rvalid: data_req_o drops, the state goes to DONE with a registered timeout flag, and lsu_err_o=1 in DONE.
- Undefined: WAIT persists indefinitely; no counter logic.

## Structure

- Package miriscv_lsu_pkg holds:
  - size encodings LDST_B=3'd0, LDST_H=3'd1, LDST_W=3'd2, LDST_BU=3'd4, LDST_HU=3'd5;
  - state encodings IDLE/WAIT/DONE;
  - TIMEOUT_CYCLES default.
- Sub-module miriscv_lsu_rdata_align: combinational shift plus sign/zero extension from (rdata, addr[1:0], size).

## Test plan

- SW 0xDEADBEEF to 0x100, rvalid in first WAIT cycle → data_addr_o=0x100, be=1111, wdata=0xDEADBEEF, stall high exactly 2 cycles.
- LB from 0x103 with rdata=0x80FF0000 → lsu_data_o=0xFFFFFF80. LBU at the same address → 0x00000080.
- SH 0x00001234 to 0x102 → be=1100, wdata=0x12341234, addr=0x100. LH from 0x102 with rdata=0x8001xxxx → 0xFFFF8001.
- LW at 0x102, or size=3 → lsu_err_o=1 same cycle, data_req_o stays 0, stall 0.
- With MIRISCV_LSU_TIMEOUT_EN, no rvalid → data_req_o drops after 255 WAIT cycles, err=1 in DONE, lsu_data_o unchanged. A later rvalid is ignored.
- reset=0 during WAIT → next cycle data_req_o=0, stall=0, state IDLE. An rvalid arriving afterward does not alter lsu_data_o.
